// File: rtl/riscv_pkg.sv
// Types and constants shared across the instruction fetch / decode path.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_R   = 7'b0110011;
  localparam logic [6:0] OPCODE_I   = 7'b0010011;
  localparam logic [6:0] OPCODE_LW  = 7'b0000011;
  localparam logic [6:0] OPCODE_SW  = 7'b0100011;
  localparam logic [6:0] OPCODE_BEQ = 7'b1100011;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Gate push/pop on occupancy; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    empty     = (count_r == CW'(0));
    full      = (count_r == CW'(DEPTH));
    count     = count_r;
    rdata     = mem_r[rd_ptr_r];
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Entry storage; contents need no reset since occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; flush outranks push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited sequential reads into a small buffer,
// valid/ready delivery to decode, and redirect with stale-response discard.
module instr_fetch #(
  parameter int unsigned      XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [6:0]      opcode_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
);
  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_entry_t    head_s;
  fetch_entry_t    wentry_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [XLEN-1:0] last_pc_r;
  logic [XLEN-1:0] redirect_pc_s;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   discard_r;
  logic [CW-1:0]   outstanding_n_s;
  logic [CW-1:0]   discard_n_s;
  logic [CW-1:0]   count_n_s;
  logic [CW:0]     credit_s;
  logic            req_r;
  logic            req_n_s;
  logic            grant_s;
  logic            push_s;
  logic            pop_s;
  logic            discard_hit_s;

  // Next-state counters; the request for next cycle is derived from them so it stays registered.
  always_comb begin
    redirect_pc_s  = redirect_pc_i & ~(XLEN'(3));
    grant_s        = req_r & imem_gnt_i;
    discard_hit_s  = imem_rvalid_i & (discard_r != CW'(0));
    pop_s          = ~fifo_empty_s & instr_ready_i & ~redirect_i;
    push_s         = imem_rvalid_i & ~redirect_i & (discard_r == CW'(0)) & (~fifo_full_s | pop_s);
    wentry_s.instr = imem_rdata_i;
    wentry_s.pc    = rsp_pc_r;
    if (redirect_i) begin
      count_n_s       = CW'(0);
      outstanding_n_s = CW'(0);
      discard_n_s     = discard_r + outstanding_r + CW'(grant_s) - CW'(imem_rvalid_i);
    end else begin
      count_n_s       = fifo_count_s + CW'(push_s) - CW'(pop_s);
      outstanding_n_s = outstanding_r + CW'(grant_s) - CW'(push_s);
      discard_n_s     = discard_r - CW'(discard_hit_s);
    end
    credit_s = {1'b0, count_n_s} + {1'b0, outstanding_n_s} + {1'b0, discard_n_s};
    req_n_s  = (credit_s < DEPTH_C);
  end

  // Fetch/response PCs, read bookkeeping and the last presented PC.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_r         <= 1'b0;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      last_pc_r     <= XLEN'(0);
      outstanding_r <= CW'(0);
      discard_r     <= CW'(0);
    end else begin
      req_r         <= req_n_s;
      outstanding_r <= outstanding_n_s;
      discard_r     <= discard_n_s;
      if (!fifo_empty_s) begin
        last_pc_r <= head_s.pc;
      end
      if (redirect_i) begin
        fetch_pc_r <= redirect_pc_s;
        rsp_pc_r   <= redirect_pc_s;
      end else begin
        if (grant_s) begin
          fetch_pc_r <= fetch_pc_r + XLEN'(4);
        end
        if (push_s) begin
          rsp_pc_r <= rsp_pc_r + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_s),
    .wdata (wentry_s),
    .pop   (pop_s),
    .flush (redirect_i),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Outputs come straight from registered state; an empty buffer shows a NOP.
  always_comb begin
    imem_req_o    = req_r;
    imem_addr_o   = fetch_pc_r;
    instr_valid_o = ~fifo_empty_s;
    if (fifo_empty_s) begin
      instr_o    = NOP;
      instr_pc_o = last_pc_r;
    end else begin
      instr_o    = head_s.instr;
      instr_pc_o = head_s.pc;
    end
    opcode_o = instr_o[6:0];
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit. It is the producer side of the instruction/opcode path that feeds the `control` decoder.
- It issues sequential word reads to instruction memory over a req/gnt/rvalid protocol and buffers the returned words in a small FIFO.
- It presents instructions to decode with a valid/ready handshake.
- It accepts branch redirects from execute, which flush the FIFO and discard in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries. Must be a power of 2 and ≥2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- imem_req_o  out  1  memory read request.
- imem_addr_o  out  XLEN  word-aligned request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid. Responses return in order, ≥1 cycle after gnt.
- imem_rdata_i  in  XLEN  read data.
- instr_valid_o  out  1  instr_o/instr_pc_o valid.
- instr_ready_i  in  1  decode accepts head instruction.
- instr_o  out  XLEN  instruction word.
- instr_pc_o  out  XLEN  PC of instr_o.
- opcode_o  out  7  instr_o[6:0], drives control opcode_i.
- redirect_i  in  1  branch taken, flush and refetch.
- redirect_pc_i  in  XLEN  new PC. Bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0.
  - instr_o=32'h0000_0013 (NOP), instr_pc_o=0.
  - FIFO empty; outstanding=0; discard=0.
  - First request is asserted the cycle after reset deasserts.
  - The memory shares this reset, so no responses arrive after reset.
- Credit rule: imem_req_o=1 iff (FIFO occupancy + outstanding) < FIFO_DEPTH.
  - outstanding = granted-but-not-returned reads that are not marked for discard.
  - Every returned word is therefore guaranteed a FIFO slot.
  - rvalid with the FIFO full is illegal; the bench asserts it never occurs.
- Request hold: while req=1 and gnt=0, imem_addr_o holds stable. The only exception is redirect.
- On req&gnt, at the next edge:
  - fetch PC += 4. Wrap-around modulo 2^XLEN is allowed.
  - outstanding += 1.
- Response path: rvalid with discard=0 writes {rdata, pc} into the FIFO tail and decrements outstanding.
  - The PC for each entry comes from an in-order PC queue of the same depth, or equivalently from a tracked response PC incremented by 4 per accepted response.
- Response latency: rvalid at cycle N makes the entry visible on instr_o at N+1 if the FIFO was empty. There is no combinational bypass.
- Output handshake:
  - instr_valid_o = FIFO not empty.
  - The head holds stable until instr_valid_o&instr_ready_i; the FIFO pops at that edge.
  - When empty, instr_o=NOP and instr_pc_o holds its last value.
- Simultaneous push and pop is legal at any occupancy, including full; occupancy is unchanged.
- Redirect (redirect_i=1 at an edge). Redirect has priority over all other events in that cycle. At that edge:
  - FIFO flushed; instr_valid_o=0 the next cycle.
  - A pop in the same cycle is ignored.
  - fetch PC and imem_addr_o = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - discard += outstanding + (req&gnt this cycle) − (rvalid this cycle); outstanding=0.
  - An rvalid in the redirect cycle is dropped.
- Discarded responses: while discard>0, each rvalid decrements discard and is dropped.
  - New requests are still issued under the credit rule; discard counts against credit.
  - The first instruction from the new PC appears ≥2 cycles after redirect.
- Back-to-back redirects: each one restarts from its own PC, and discard accumulates.
- Counter widths: outstanding and discard are clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package riscv_pkg holds:
  - XLEN.
  - Opcode constants OPCODE_R/I/LW/SW/BEQ, shared with control.
  - NOP constant 32'h0000_0013.
  - fetch_entry_t {instr, pc}.
- One sub-module: fetch_fifo. It is a synchronous FIFO of fetch_entry_t with push/pop/flush/full/empty/count ports, and the same clock and reset.

Test Plan:
- Reset then a zero-wait memory (gnt=1, rvalid 1 cycle later), ready=1 → imem_addr 0x0,0x4,0x8…; instr_pc_o 0x0 first valid at cycle 3 after reset release; one instruction per cycle thereafter.
- Decode stall: hold ready=0 for 10 cycles → FIFO fills to 2, imem_req_o drops to 0, head stays instr@0x0; on release, in-order 0x0,0x4,0x8 with no loss or duplicate.
- Memory stall: gnt=0 for 5 cycles → imem_addr_o stable at 0x8 and req held; rvalid latency 3 → PCs still in order.
- Redirect to 0x103 with 2 reads outstanding → next addr 0x100, two stale rvalids dropped, first valid instr_pc_o=0x100, opcode_o matches mem[0x100][6:0].
- Redirect in the same cycle as rvalid, pop and gnt → rvalid dropped, pop ignored, discard counts the granted read; next valid PC = redirect target.
- Mid-run reset with FIFO full → all outputs at reset values the next cycle; refetch begins at RESET_PC.
